// File: rtl/if_stage_if.sv
// IF-stage boundary signals: IF->ID handshake/payload, ID->PC redirect, instruction SRAM port.
// master = if_stage side; slave = the ID stage / SRAM side.
interface if_stage_if #(
   parameter int unsigned IF_TO_ID_BUS_WD = 64,
   parameter int unsigned ID_TO_PC_BUS_WD = 33
);
   logic                       ID_allow_in;
   logic [ID_TO_PC_BUS_WD-1:0] ID_to_PC_bus;
   logic                       IF_to_ID_valid;
   logic [IF_TO_ID_BUS_WD-1:0] IF_to_ID_bus;
   logic                       inst_sram_en;
   logic [31:0]                inst_sram_addr;
   logic [31:0]                inst_sram_rdata;

   modport master (
      input  ID_allow_in, ID_to_PC_bus, inst_sram_rdata,
      output IF_to_ID_valid, IF_to_ID_bus, inst_sram_en, inst_sram_addr
   );

   modport slave (
      output ID_allow_in, ID_to_PC_bus, inst_sram_rdata,
      input  IF_to_ID_valid, IF_to_ID_bus, inst_sram_en, inst_sram_addr
   );
endinterface

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: owns the PC, issues reads to a 1-cycle synchronous
// instruction SRAM, and holds the fetched word in a one-entry buffer while ID stalls.
module if_stage #(
   parameter logic [31:0] RESET_PC        = 32'hBFC0_0000,
   parameter int unsigned IF_TO_ID_BUS_WD = 64,
   parameter int unsigned ID_TO_PC_BUS_WD = 33
) (
   input logic      clk,
   input logic      reset,
   if_stage_if.master bus
);

   localparam int unsigned PC_W = 32;

   logic            IF_valid;
   logic [PC_W-1:0] IF_pc;
   logic [PC_W-1:0] inst_buf;
   logic            inst_buf_valid;

   logic            IF_ready_go;
   logic            IF_allow_in;
   logic            redirect;
   logic [PC_W-1:0] redirect_target;
   logic [PC_W-1:0] seq_pc;
   logic [PC_W-1:0] next_pc;
   logic            fetch_en;
   logic            buf_capture;
   logic [PC_W-1:0] inst_word;

   // Handshake: SRAM latency is fixed, so a valid IF entry is always ready to go.
   always_comb begin
      IF_ready_go = 1'b1;
      IF_allow_in = ~IF_valid | (IF_ready_go & bus.ID_allow_in);
      fetch_en    = ~reset & IF_allow_in;
      buf_capture = IF_valid & ~inst_buf_valid & ~bus.ID_allow_in;
   end

   // Pre-IF next PC; the redirect is only consumed on a cycle that actually issues.
   always_comb begin
      redirect        = IF_valid & bus.ID_to_PC_bus[0];
      redirect_target = bus.ID_to_PC_bus[ID_TO_PC_BUS_WD-1:1];
      seq_pc          = IF_pc + PC_W'(4);
      next_pc         = redirect ? redirect_target : seq_pc;
   end

   // SRAM rdata is only trusted the first cycle after issue; afterwards the buffer holds it.
   always_comb begin
      inst_word           = inst_buf_valid ? inst_buf : bus.inst_sram_rdata;
      bus.inst_sram_en    = fetch_en;
      bus.inst_sram_addr  = next_pc;
      bus.IF_to_ID_valid  = IF_valid & IF_ready_go;
      bus.IF_to_ID_bus    = IF_TO_ID_BUS_WD'({seq_pc, inst_word});
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         IF_valid       <= 1'b0;
         IF_pc          <= RESET_PC - PC_W'(4);
         inst_buf       <= '0;
         inst_buf_valid <= 1'b0;
      end else begin
         if (fetch_en) begin
            IF_valid <= 1'b1;
            IF_pc    <= next_pc;
         end
         // Capture needs ID_allow_in=0 with IF valid, so it never overlaps a new issue.
         if (IF_allow_in) begin
            inst_buf_valid <= 1'b0;
         end else if (buf_capture) begin
            inst_buf       <= bus.inst_sram_rdata;
            inst_buf_valid <= 1'b1;
         end
      end
   end

endmodule
